// File: rtl/match_ctrl_if.sv
// match_ctrl_if
//   Bundles the game-side signals of the match sequencer.
//   slave  : match_ctrl side (consumes tick/start/scores, drives controls)
//   master : game/testbench side
//   tick      game-tick enable, one clk wide
//   start     debounced start button level
//   score_p1  player 1 score (4 bit)
//   score_p2  player 2 score (4 bit)
//   serve     one-cycle ball launch pulse
//   run       ball in play
//   score_clr one-cycle score clear pulse
//   blank     scoreboard blank (blinks in OVER)
//   winner    00 none, 01 p1, 10 p2
//   state     current sequencer state code
interface match_ctrl_if;
  logic       tick;
  logic       start;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       serve;
  logic       run;
  logic       score_clr;
  logic       blank;
  logic [1:0] winner;
  logic [2:0] state;

  modport slave (
    input  tick, start, score_p1, score_p2,
    output serve, run, score_clr, blank, winner, state
  );

  modport master (
    output tick, start, score_p1, score_p2,
    input  serve, run, score_clr, blank, winner, state
  );
endinterface

// File: rtl/match_ctrl.sv
// match_ctrl
//   Match-level sequencer for the pong datapath: serve countdown, point
//   detection, post-point pause and winner/blink handling.
//   clk   system clock (12 MHz)
//   reset synchronous, active-high
//   bus   match_ctrl_if.slave (tick, start, scores in; controls out)
//
//   state  | meaning
//   -------+---------------------------------------------
//   IDLE   | waiting for first start edge
//   SERVE  | counting SERVE_TICKS before launching ball
//   RALLY  | ball in play, watching for score change
//   POINT  | pause of POINT_TICKS, then win check
//   OVER   | winner declared, scoreboard blinks
module match_ctrl #(
  parameter int SERVE_TICKS = 1000,
  parameter int POINT_TICKS = 500,
  parameter int WIN_SCORE   = 9,
  parameter int BLINK_TICKS = 250
) (
  input  logic         clk,
  input  logic         reset,
  match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [15:0] SERVE_LD = 16'(SERVE_TICKS);
  localparam logic [15:0] POINT_LD = 16'(POINT_TICKS);
  localparam logic [15:0] BLINK_LD = 16'(BLINK_TICKS);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start_q;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s2_q, s2_d;
  logic        serve_q, serve_d;
  logic        run_q, run_d;
  logic        score_clr_q, score_clr_d;
  logic        blank_q, blank_d;
  logic [1:0]  winner_q, winner_d;

  logic start_rise;
  logic tick_done;

  assign start_rise = bus.start & ~start_q;
  assign tick_done  = bus.tick && (cnt_q == 16'd1);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    blank_d     = 1'b0;
    score_clr_d = 1'b0;
    cnt_d       = (bus.tick && cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    // baseline freezes only while the ball is in play
    s1_d        = (state_q == S_RALLY) ? s1_q : bus.score_p1;
    s2_d        = (state_q == S_RALLY) ? s2_q : bus.score_p2;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d     = S_SERVE;
          score_clr_d = 1'b1;
          winner_d    = 2'b00;
          cnt_d       = SERVE_LD;
        end
      end
      S_SERVE: begin
        if (tick_done) state_d = S_RALLY;
      end
      S_RALLY: begin
        // inequality so a 15->0 wrap still counts as a point
        if (bus.score_p1 != s1_q || bus.score_p2 != s2_q) begin
          state_d = S_POINT;
          cnt_d   = POINT_LD;
        end
      end
      S_POINT: begin
        if (tick_done) begin
          if (bus.score_p1 >= WIN) begin
            state_d  = S_OVER;
            winner_d = 2'b01;
            cnt_d    = BLINK_LD;
          end else if (bus.score_p2 >= WIN) begin
            state_d  = S_OVER;
            winner_d = 2'b10;
            cnt_d    = BLINK_LD;
          end else begin
            state_d = S_SERVE;
            cnt_d   = SERVE_LD;
          end
        end
      end
      S_OVER: begin
        blank_d = blank_q;
        // a restart takes priority over a coincident blink reload
        if (start_rise) begin
          state_d     = S_SERVE;
          score_clr_d = 1'b1;
          winner_d    = 2'b00;
          cnt_d       = SERVE_LD;
          blank_d     = 1'b0;
        end else if (tick_done) begin
          blank_d = ~blank_q;
          cnt_d   = BLINK_LD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    run_d   = (state_d == S_RALLY);
    serve_d = (state_d == S_RALLY) && (state_q != S_RALLY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      start_q     <= 1'b0;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      serve_q     <= 1'b0;
      run_q       <= 1'b0;
      score_clr_q <= 1'b0;
      blank_q     <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= bus.start;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      serve_q     <= serve_d;
      run_q       <= run_d;
      score_clr_q <= score_clr_d;
      blank_q     <= blank_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.serve     = serve_q;
  assign bus.run       = run_q;
  assign bus.score_clr = score_clr_q;
  assign bus.blank     = blank_q;
  assign bus.winner    = winner_q;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match-level sequencer for the pong game datapath. It sits between the debounced start button and the game/score blocks, on the 12 MHz system clock, and is advanced by the one-cycle game tick. It runs the serve countdown, detects scored points, holds a post-point pause, and declares a winner at a target score. It drives the game's serve/run controls, a score-clear pulse, and the scoreboard blink.

## Interface
Parameters:
- SERVE_TICKS, 1000, game ticks of countdown before each serve (≥1)
- POINT_TICKS, 500, game ticks of pause after a point (≥1)
- WIN_SCORE, 9, score (1..15) at which a player wins
- BLINK_TICKS, 250, game ticks per scoreboard blink half-period in OVER (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- tick  in  1  one-clk-wide game-tick enable
- start  in  1  debounced start button level
- score_p1  in  4  player 1 score from game
- score_p2  in  4  player 2 score from game
- serve  out  1  one-cycle pulse: launch ball
- run  out  1  high while ball in play (RALLY)
- score_clr  out  1  one-cycle pulse: zero both scores
- blank  out  1  scoreboard blank (blink in OVER)
- winner  out  2  00 none, 01 p1, 10 p2
- state  out  3  current state encoding

## Operation
- States: IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4. Codes 5–7 go to IDLE on the next clk.
- One 16-bit tick counter `cnt`. It is loaded on state entry, decrements only on cycles with tick=1, and holds otherwise.
- Start edge: `start_q` is registered every clk. `start_rise = start & ~start_q`. `start_q` resets to 0, so start held high through reset produces one edge.
- Score baseline: `s1_q`/`s2_q` follow score_p1/score_p2 every clk in every state except RALLY. In RALLY they hold.
- IDLE → SERVE on start_rise. On that transition score_clr=1 for one cycle, winner is cleared, and cnt=SERVE_TICKS.
- SERVE: when tick=1 and cnt==1, go to RALLY.
- RALLY: serve=1 on the first clk in RALLY only. run=1 throughout RALLY.
  - If score_p1≠s1_q or score_p2≠s2_q, go to POINT with cnt=POINT_TICKS.
  - The compare is inequality, so a 15→0 wrap counts as a point.
  - If both scores change in the same cycle, it is a single POINT entry.
- POINT: when tick=1 and cnt==1, evaluate the scores sampled that cycle:
  - score_p1≥WIN_SCORE → OVER, winner=01. This check has priority if both are ≥WIN_SCORE.
  - else score_p2≥WIN_SCORE → OVER, winner=10.
  - else → SERVE with cnt=SERVE_TICKS.
- OVER:
  - cnt is loaded with BLINK_TICKS on entry. On tick with cnt==1, blank toggles and cnt reloads.
  - blank=0 on entry to OVER and forced 0 in all other states.
  - start_rise → SERVE with score_clr=1, winner=00, cnt=SERVE_TICKS. If start_rise and a blink tick coincide, start_rise wins.
- start_rise outside IDLE and OVER is ignored.

## Timing
- All outputs are registered. state, serve, score_clr and blank update on the clk edge that performs the transition. serve is valid in the same cycle state first reads 2.
- Reset values: state=IDLE, run=0, serve=0, score_clr=0, blank=0, winner=00, cnt=0, start_q=0, s1_q=s2_q=0.
- Reset has priority over every transition, including mid-countdown and in the same cycle as start_rise or a score change.
- Latencies:
  - IDLE→SERVE: 1 clk after the start edge.
  - SERVE→RALLY: on the SERVE_TICKS-th tick after entry.
  - Score change→POINT: 1 clk.
  - POINT exit: on the POINT_TICKS-th tick after entry.
- A tick in the same cycle as the entry load is not counted. Counting starts with the next clk.
- A score change during SERVE, POINT or OVER never triggers POINT, because the baseline tracks it.

## Test plan
- Reset then start pulse, SERVE_TICKS=3 with a tick every 4 clk:
  - score_clr high exactly 1 clk at the IDLE→SERVE edge.
  - state=2 and serve=1 on the 3rd tick.
  - serve=0 on the next clk; run=1.
- In RALLY, raise score_p1 0→1 → state=3 next clk and run=0. After POINT_TICKS ticks → state=1, winner=00.
- score_p1=8→9 with WIN_SCORE=9 → POINT then OVER with winner=01. blank toggles every BLINK_TICKS ticks. start edge → SERVE, score_clr pulse, winner=00, blank=0.
- Both scores change in the same cycle (p1=9, p2=9) → one POINT entry, then winner=01. score_p2 15→0 wrap in RALLY → POINT.
- Hold start high across reset → exactly one IDLE→SERVE. Toggle start in RALLY → no state change.
- Assert reset mid-SERVE and mid-OVER coincident with tick and start_rise → next clk all outputs at reset values, state=0.
